// File: rtl/apb_controller.sv
// AHB-to-APB bridge controller: sequences AHB single and pipelined transfers into
// APB SETUP/ENABLE cycles and drives the APB request signals plus hready_out.
module apb_controller #(
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32,
  parameter int unsigned NSEL = 3
) (
  input  logic            hclk,
  input  logic            hreset,
  input  logic            valid,
  input  logic            hwrite,
  input  logic            hwrite_reg,
  input  logic [AW-1:0]   haddr,
  input  logic [AW-1:0]   haddr1,
  input  logic [AW-1:0]   haddr2,
  input  logic [DW-1:0]   hwdata,
  input  logic [DW-1:0]   hwdata1,
  input  logic            pready,
  output logic [NSEL-1:0] psel,
  output logic            penable,
  output logic            pwrite,
  output logic [AW-1:0]   paddr,
  output logic [DW-1:0]   pwdata,
  output logic            hready_out
);

  typedef enum logic [2:0] {
    StIdle,
    StWwait,
    StRead,
    StWrite,
    StWriteP,
    StRenable,
    StWenable,
    StWenableP
  } state_e;

  state_e state_q, state_d, idle_next;

  logic [NSEL-1:0] psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            pwrite_q, pwrite_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;

  // Peripheral map: 0x80.. -> slot 0, 0x84..0x8B -> slot 1, anything else unselected.
  function automatic logic [NSEL-1:0] decode(input logic [AW-1:0] addr);
    logic [5:0] top;
    top    = addr[AW-1 -: 6];
    decode = '0;
    if (top == 6'b100000) begin
      decode = NSEL'(1);
    end else if (top == 6'b100001 || top == 6'b100010) begin
      decode = NSEL'(2);
    end
  endfunction

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= StIdle;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  always_comb begin
    idle_next = StIdle;
    if (valid) begin
      idle_next = hwrite ? StWwait : StRead;
    end

    state_d = StIdle;
    case (state_q)
      StIdle:     state_d = idle_next;
      StWwait:    state_d = valid ? StWriteP : StWrite;
      StRead:     state_d = StRenable;
      StWrite:    state_d = valid ? StWenableP : StWenable;
      StWriteP:   state_d = StWenableP;
      StRenable,
      StWenable:  state_d = pready ? idle_next : state_q;
      StWenableP: begin
        if (!pready) begin
          state_d = StWenableP;
        end else if (!hwrite_reg) begin
          state_d = StRead;
        end else begin
          state_d = valid ? StWriteP : StWrite;
        end
      end
      default:    state_d = StIdle;
    endcase
  end

  // Registered outputs take the values belonging to the state being entered.
  always_comb begin
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;

    unique case (state_d)
      StIdle, StWwait: begin
        psel_d    = '0;
        penable_d = 1'b0;
      end
      StRead: begin
        paddr_d   = haddr;
        pwrite_d  = 1'b0;
        psel_d    = decode(haddr);
        penable_d = 1'b0;
      end
      StWrite, StWriteP: begin
        // First write of a burst still has its address one stage back; later ones two.
        if (state_q == StWwait) begin
          paddr_d  = haddr1;
          pwdata_d = hwdata;
          psel_d   = decode(haddr1);
        end else begin
          paddr_d  = haddr2;
          pwdata_d = hwdata1;
          psel_d   = decode(haddr2);
        end
        pwrite_d  = 1'b1;
        penable_d = 1'b0;
      end
      StRenable, StWenable, StWenableP: begin
        penable_d = 1'b1;
      end
      default: begin
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase

    unique case (state_q)
      StIdle, StWwait:                  hready_out = 1'b1;
      StRead, StWrite, StWriteP:        hready_out = 1'b0;
      StRenable, StWenable, StWenableP: hready_out = pready;
      default:                          hready_out = 1'b1;
    endcase
  end

  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;

endmodule
